// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO plus a drain sequencer feeding uart_tx.
// Producers push bytes at any rate. The sequencer launches one byte at a time
// and waits for each serial frame to finish before launching the next.
//
// Handshake: i_Wr_DV is a strobe with no back-pressure. A write is accepted
// when o_Full=0 and dropped when o_Full=1, in which case o_Overflow pulses.
// Toward uart_tx, o_Tx_DV is a single-cycle launch pulse. It is only issued
// while i_Tx_Active=0 and i_Tx_Done=0.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_Clock,
  input  logic                  i_Rst_L,
  input  logic                  i_Wr_DV,
  input  logic [7:0]            i_Wr_Byte,
  output logic                  o_Full,
  output logic                  o_Empty,
  output logic [DEPTH_LOG2:0]   o_Count,
  output logic                  o_Overflow,
  output logic                  o_Tx_DV,
  output logic [7:0]            o_Tx_Byte,
  input  logic                  i_Tx_Active,
  input  logic                  i_Tx_Done,
  output logic [1:0]            o_State
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] COUNT_FULL = DEPTH[DEPTH_LOG2:0];

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_WAIT_ACTIVE = 2'd1,
    S_WAIT_DONE   = 2'd2,
    S_COOLDOWN    = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [7:0]              mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic                    tx_dv_q, tx_dv_d;
  logic [7:0]              tx_byte_q, tx_byte_d;
  logic                    overflow_q, overflow_d;
  logic                    full, empty, wr_en, pop;

  // Flags come from the registered count, so a write is never visible on the same cycle.
  assign full  = (count_q == COUNT_FULL);
  assign empty = (count_q == '0);

  // A write while full is dropped, even if a pop frees a slot on the same cycle.
  assign wr_en = i_Wr_DV & ~full;

  // Only launch when uart_tx is fully quiet, which also covers a frame left
  // running across a reset of this block.
  assign pop = (state_q == S_IDLE) & ~empty & ~i_Tx_Active & ~i_Tx_Done;

  // Storage array: written only on accepted writes. The contents need no reset.
  always_ff @(posedge i_Clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= i_Wr_Byte;
  end

  // Pointer, count and output next-state logic, plus the drain FSM transitions.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    tx_dv_d    = 1'b0;
    tx_byte_d  = tx_byte_q;
    overflow_d = i_Wr_DV & full;

    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;

    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          tx_byte_d = mem_q[rd_ptr_q];
          tx_dv_d   = 1'b1;
          state_d   = S_WAIT_ACTIVE;
        end
      end
      S_WAIT_ACTIVE: if (i_Tx_Active) state_d = S_WAIT_DONE;
      S_WAIT_DONE:   if (i_Tx_Done)   state_d = S_COOLDOWN;
      // Wait for the done pulse to end, so the next launch finds uart_tx in IDLE.
      S_COOLDOWN:    if (!i_Tx_Done)  state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_dv_q    <= 1'b0;
      tx_byte_q  <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_dv_q    <= tx_dv_d;
      tx_byte_q  <= tx_byte_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_Full     = full;
  assign o_Empty    = empty;
  assign o_Count    = count_q;
  assign o_Overflow = overflow_q;
  assign o_Tx_DV    = tx_dv_q;
  assign o_Tx_Byte  = tx_byte_q;
  assign o_State    = state_q;

endmodule
